// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported, fixed-latency memory between the fetch (i) and data (d) ports.
// Each access runs IDLE -> ISSUE -> [WAIT] -> DONE and returns data with a one-cycle done pulse.
module unified_mem_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_done,
    output logic [31:0] i_rdata,
    output logic        i_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        d_stall,
    output logic        m_en,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam logic [3:0] WAIT_INIT  = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state_q, state_d;
    logic        own_d_q, own_d_d;
    logic [3:0]  starve_q, starve_d;
    logic [3:0]  wait_q, wait_d;
    logic        m_en_q, m_en_d;
    logic        m_we_q, m_we_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic        i_done_q, i_done_d;
    logic        d_done_q, d_done_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        req_any_s;
    logic        d_win_s;

    assign req_any_s = i_req | d_req;
    assign d_win_s   = d_req & (~i_req | (starve_q < STARVE_LIM));

    // State register
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the m_we register doubles as the latched write flag during ISSUE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_any_s) state_d = S_ISSUE; else state_d = S_IDLE;
            S_ISSUE: if (m_we_q) state_d = S_DONE; else state_d = S_WAIT;
            S_WAIT:  if (wait_q == 4'd0) state_d = S_DONE; else state_d = S_WAIT;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; strobes and done pulses default low each cycle
    always_comb begin
        own_d_d   = own_d_q;
        starve_d  = starve_q;
        wait_d    = wait_q;
        m_en_d    = 1'b0;
        m_we_d    = 1'b0;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_any_s) begin
                    own_d_d = d_win_s;
                    m_en_d  = 1'b1;
                    if (d_win_s) begin
                        m_we_d    = d_we;
                        m_addr_d  = d_addr;
                        m_wdata_d = d_wdata;
                        if (i_req) begin
                            starve_d = (starve_q >= STARVE_LIM) ? STARVE_LIM : starve_q + 4'd1;
                        end else begin
                            starve_d = 4'd0;
                        end
                    end else begin
                        m_we_d   = 1'b0;
                        m_addr_d = i_addr;
                        starve_d = 4'd0;
                    end
                end else begin
                    own_d_d = own_d_q;
                end
            end
            S_ISSUE: begin
                wait_d = WAIT_INIT;
                if (m_we_q) begin
                    d_done_d = own_d_q;
                    i_done_d = ~own_d_q;
                end else begin
                    d_done_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (wait_q == 4'd0) begin
                    d_done_d = own_d_q;
                    i_done_d = ~own_d_q;
                    if (own_d_q) begin
                        d_rdata_d = m_rdata;
                    end else begin
                        i_rdata_d = m_rdata;
                    end
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_DONE: begin
                wait_d = wait_q;
            end
            default: begin
                wait_d = 4'd0;
            end
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge CLK) begin
        if (Reset) begin
            own_d_q   <= 1'b0;
            starve_q  <= 4'd0;
            wait_q    <= 4'd0;
            m_en_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= 32'd0;
            m_wdata_q <= 32'd0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            i_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
        end else begin
            own_d_q   <= own_d_d;
            starve_q  <= starve_d;
            wait_q    <= wait_d;
            m_en_q    <= m_en_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign m_en    = m_en_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_done  = i_done_q;
    assign d_done  = d_done_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign i_stall = i_req & ~i_done_q;
    assign d_stall = d_req & ~d_done_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: a transaction table plus hand-written sequences
// for simultaneous requests, starvation, latency extremes and reset during an access.
module tb_unified_mem_arbiter;
    logic        CLK = 1'b0;
    logic        Reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_done, d_done, i_stall, d_stall;
    logic [31:0] i_rdata, d_rdata;
    logic        m_en, m_we;
    logic [31:0] m_addr, m_wdata, m_rdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    unified_mem_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) dut (
        .CLK(CLK), .Reset(Reset),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    // Memory model, latency 2: 0x40 preloaded with DEADBEEF while Reset is high
    logic [31:0] mem [0:255];
    logic [7:0]  rd_idx0, rd_idx1;
    logic [1:0]  rd_v;
    always @(posedge CLK) begin
        if (Reset) mem[16] <= 32'hDEAD_BEEF;
        else if (m_en && m_we) mem[m_addr[9:2]] <= m_wdata;
        rd_v    <= {rd_v[0], m_en & ~m_we};
        rd_idx0 <= m_addr[9:2];
        rd_idx1 <= rd_idx0;
    end
    assign m_rdata = rd_v[1] ? mem[rd_idx1] : 32'hBAD0_BAD0;

    // Latency-sweep instances (fetch-only traffic)
    logic        zero1 = 1'b0;
    logic [31:0] zero32 = 32'd0;
    logic        lreq1, lreq8;
    logic        l_done1, l_done8, l_istall1, l_istall8, l_ddone1, l_ddone8, l_dstall1, l_dstall8;
    logic [31:0] l_rd1, l_rd8, l_drd1, l_drd8;
    logic        l_en1, l_en8, l_we1, l_we8;
    logic [31:0] l_addr1, l_addr8, l_wd1, l_wd8, l_mrd1, l_mrd8;
    logic        v1;
    logic [7:0]  v8;
    always @(posedge CLK) begin
        v1 <= l_en1 & ~l_we1;
        v8 <= {v8[6:0], l_en8 & ~l_we8};
    end
    assign l_mrd1 = v1    ? 32'h1111_0001 : 32'h0;
    assign l_mrd8 = v8[7] ? 32'h8888_0008 : 32'h0;

    unified_mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_lat1 (
        .CLK(CLK), .Reset(Reset),
        .i_req(lreq1), .i_addr(zero32), .i_done(l_done1), .i_rdata(l_rd1), .i_stall(l_istall1),
        .d_req(zero1), .d_we(zero1), .d_addr(zero32), .d_wdata(zero32),
        .d_done(l_ddone1), .d_rdata(l_drd1), .d_stall(l_dstall1),
        .m_en(l_en1), .m_we(l_we1), .m_addr(l_addr1), .m_wdata(l_wd1), .m_rdata(l_mrd1)
    );

    unified_mem_arbiter #(.MEM_LAT(8), .STARVE_MAX(4)) u_lat8 (
        .CLK(CLK), .Reset(Reset),
        .i_req(lreq8), .i_addr(zero32), .i_done(l_done8), .i_rdata(l_rd8), .i_stall(l_istall8),
        .d_req(zero1), .d_we(zero1), .d_addr(zero32), .d_wdata(zero32),
        .d_done(l_ddone8), .d_rdata(l_drd8), .d_stall(l_dstall8),
        .m_en(l_en8), .m_we(l_we8), .m_addr(l_addr8), .m_wdata(l_wd8), .m_rdata(l_mrd8)
    );

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          exp_cyc;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vt [7];

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One access from cycle 0 (IDLE) through done; leaves the bench in the following IDLE cycle
    task automatic run_txn(input logic is_d, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, output int cyc, output int men,
                           output logic [31:0] en_addr, output logic en_we,
                           output logic stall0, output logic [31:0] rd);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        #1;
        stall0 = is_d ? d_stall : i_stall;
        cyc = 0; men = 0; en_addr = 32'hFFFF_FFFF; en_we = 1'bx; rd = 32'hx;
        for (int k = 0; k < 20; k++) begin
            tick();
            cyc++;
            if (m_en) begin
                men++; en_addr = m_addr; en_we = m_we;
            end
            if (is_d ? d_done : i_done) begin
                rd = is_d ? d_rdata : i_rdata;
                break;
            end
        end
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        tick();
    endtask

    initial begin
        int          cyc, men, dc, ic, c1, c8, m1, m8, ev;
        logic [31:0] en_addr, rd, drd, ird, r1, r8;
        logic        en_we, stall0, st_at_d;
        logic [9:0]  exp_ev;
        logic [9:0]  got_ev;

        vt[0] = '{1'b0, 1'b0, 32'h40, 32'h0,          4, 32'hDEAD_BEEF};
        vt[1] = '{1'b1, 1'b1, 32'h80, 32'h1234_5678,  2, 32'h0};
        vt[2] = '{1'b1, 1'b0, 32'h80, 32'h0,          4, 32'h1234_5678};
        vt[3] = '{1'b1, 1'b1, 32'h84, 32'hCAFE_F00D,  2, 32'h1234_5678};
        vt[4] = '{1'b0, 1'b0, 32'h84, 32'h0,          4, 32'hCAFE_F00D};
        vt[5] = '{1'b1, 1'b0, 32'h40, 32'h0,          4, 32'hDEAD_BEEF};
        vt[6] = '{1'b0, 1'b0, 32'h80, 32'h0,          4, 32'h1234_5678};

        Reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; lreq1 = 1'b0; lreq8 = 1'b0;
        repeat (3) tick();
        Reset = 1'b0;
        #1;
        chk("rst_m_en", {31'd0, m_en}, 32'd0);
        chk("rst_m_we", {31'd0, m_we}, 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_m_wdata", m_wdata, 32'd0);
        chk("rst_dones", {30'd0, i_done, d_done}, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        tick();

        for (int i = 0; i < 7; i++) begin
            run_txn(vt[i].is_d, vt[i].we, vt[i].addr, vt[i].wdata, cyc, men, en_addr, en_we, stall0, rd);
            chk($sformatf("v%0d_cycles", i), cyc, vt[i].exp_cyc);
            chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rd);
            chk($sformatf("v%0d_m_en_count", i), men, 32'd1);
            chk($sformatf("v%0d_m_addr", i), en_addr, vt[i].addr);
            chk($sformatf("v%0d_m_we", i), {31'd0, en_we}, {31'd0, vt[i].we});
            chk($sformatf("v%0d_stall_c0", i), {31'd0, stall0}, 32'd1);
        end

        // Simultaneous requests: d first, i granted in the IDLE cycle after d's DONE
        i_req = 1'b1; i_addr = 32'h84; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        dc = 0; ic = 0; st_at_d = 1'b0; drd = 32'h0; ird = 32'h0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (d_done && dc == 0) begin
                dc = k; drd = d_rdata; st_at_d = i_stall; d_req = 1'b0;
            end
            if (i_done && ic == 0) begin
                ic = k; ird = i_rdata; i_req = 1'b0;
            end
            if (dc != 0 && ic != 0) break;
        end
        i_req = 1'b0; d_req = 1'b0;
        tick();
        chk("sim_d_cycle", dc, 32'd4);
        chk("sim_i_cycle", ic, 32'd9);
        chk("sim_d_rdata", drd, 32'hDEAD_BEEF);
        chk("sim_i_rdata", ird, 32'hCAFE_F00D);
        chk("sim_i_stall_at_d_done", {31'd0, st_at_d}, 32'd1);

        // Starvation: i held, d writes held -> d d d d i d d d d i
        exp_ev = 10'b01_1110_1111;
        got_ev = 10'bx;
        ev = 0;
        i_req = 1'b1; i_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h5555_AAAA;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (d_done) begin
                got_ev[ev] = 1'b1; ev++;
            end else if (i_done) begin
                got_ev[ev] = 1'b0; ev++;
            end
            if (ev == 10) break;
        end
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        tick();
        for (int e = 0; e < 10; e++) begin
            chk($sformatf("starve_ev%0d", e), {31'd0, got_ev[e]}, {31'd0, exp_ev[e]});
        end

        // Latency sweep on MEM_LAT=1 and MEM_LAT=8 instances
        lreq1 = 1'b1; lreq8 = 1'b1;
        c1 = 0; c8 = 0; m1 = 0; m8 = 0; r1 = 32'h0; r8 = 32'h0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (l_en1) m1++;
            if (l_en8) m8++;
            if (l_done1 && c1 == 0) begin
                c1 = k; r1 = l_rd1; lreq1 = 1'b0;
            end
            if (l_done8 && c8 == 0) begin
                c8 = k; r8 = l_rd8; lreq8 = 1'b0;
            end
            if (c1 != 0 && c8 != 0) break;
        end
        lreq1 = 1'b0; lreq8 = 1'b0;
        tick();
        chk("lat1_cycle", c1, 32'd3);
        chk("lat8_cycle", c8, 32'd10);
        chk("lat1_rdata", r1, 32'h1111_0001);
        chk("lat8_rdata", r8, 32'h8888_0008);
        chk("lat1_m_en_count", m1, 32'd1);
        chk("lat8_m_en_count", m8, 32'd1);

        // Reset during WAIT of a d read; request held through reset is re-granted
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        tick();
        chk("rmid_issue_m_en", {31'd0, m_en}, 32'd1);
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        #1;
        chk("rmid_no_done", {31'd0, d_done}, 32'd0);
        chk("rmid_m_en", {31'd0, m_en}, 32'd0);
        chk("rmid_m_addr", m_addr, 32'd0);
        chk("rmid_d_rdata", d_rdata, 32'd0);
        chk("rmid_i_rdata", i_rdata, 32'd0);
        chk("rmid_d_stall", {31'd0, d_stall}, 32'd1);
        cyc = 0; rd = 32'h0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (d_done) begin
                cyc = k; rd = d_rdata; break;
            end
        end
        d_req = 1'b0;
        tick();
        chk("rmid_regrant_cycle", cyc, 32'd4);
        chk("rmid_regrant_rdata", rd, 32'hDEAD_BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
